// File: rtl/load_mem_responder.sv
// Load-unit memory responder: queued read requests, fixed-latency word-array read, lane extract/extend.
// Optional MISALIGN_TRAP_EN: misaligned half/word and reserved size return an invalid (error) response.
module load_mem_responder #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             mem_read,
    output logic             req_ready,
    input  logic [31:0]      mem_addr2,
    input  logic [1:0]       mem_size,
    input  logic             mem_sign,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_resp,
    output logic             mem_resp_valid,
    output logic [31:0]      mem_data_out,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             we,
    input  logic [31:0]      waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic [AW-1:0]    idx;
        logic [1:0]       lane;
        logic [1:0]       size;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [31:0]   mem [MEM_WORDS];
    req_t          fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    state_t        state;
    logic [CW-1:0] cnt;
    req_t          svc;
    req_t          in_req;

    logic fifo_empty, accept, done, slot_free, pop, bypass, push;
    logic unused_addr;

    assign in_req     = '{idx: mem_addr2[AW+1:2], lane: mem_addr2[1:0], size: mem_size,
                          sign: mem_sign, tag: req_tag};
    assign fifo_empty = (count == '0);
    assign req_ready  = (count != (PW+1)'(DEPTH));
    assign accept     = mem_read && req_ready && !flush;
    assign done       = (state == BUSY) && (cnt == '0);
    // The service slot frees up at the response edge, so the next request starts with no bubble.
    assign slot_free  = (state == IDLE) || done;
    assign pop        = !flush && slot_free && !fifo_empty;
    assign bypass     = accept && slot_free && fifo_empty;
    assign push       = accept && !bypass;
    assign unused_addr = ^{mem_addr2[31:AW+2], waddr[31:AW+2], waddr[1:0]};

    function automatic logic [31:0] extract(input logic [31:0] word, input req_t r);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*r.lane +: 8];
        h = r.lane[1] ? word[31:16] : word[15:0];
        case (r.size)
            2'b00:   return r.sign ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return r.sign ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input req_t r);
        return (r.size == 2'b01 && r.lane[0]) || (r.size == 2'b10 && r.lane != 2'b00) ||
               (r.size == 2'b11);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            svc            <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            mem_resp       <= 1'b0;
            mem_resp_valid <= 1'b0;
            mem_data_out   <= '0;
            resp_tag       <= '0;
        end else if (flush) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            mem_resp       <= 1'b0;
            mem_resp_valid <= 1'b0;
        end else begin
            mem_resp       <= 1'b0;
            mem_resp_valid <= 1'b0;
            // Array read is sampled here, before this edge's write lands.
            if (done) begin
                mem_resp <= 1'b1;
                resp_tag <= svc.tag;
`ifdef MISALIGN_TRAP_EN
                if (misaligned(svc)) begin
                    mem_resp_valid <= 1'b0;
                    mem_data_out   <= '0;
                end else begin
                    mem_resp_valid <= 1'b1;
                    mem_data_out   <= extract(mem[svc.idx], svc);
                end
`else
                mem_resp_valid <= 1'b1;
                mem_data_out   <= extract(mem[svc.idx], svc);
`endif
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

            if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (pop) begin
                svc   <= fifo_mem[rd_ptr];
                cnt   <= CW'(LATENCY - 1);
                state <= BUSY;
            end else if (bypass) begin
                svc   <= in_req;
                cnt   <= CW'(LATENCY - 1);
                state <= BUSY;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_load_mem_responder.sv
// Scoreboard bench for load_mem_responder: randomized and directed loads against a timing/data model.
module tb_load_mem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk, rst_n, flush, mem_read, req_ready, mem_sign;
    logic [31:0] mem_addr2;
    logic [1:0]  mem_size;
    logic [3:0]  req_tag, resp_tag, wstrb;
    logic        mem_resp, mem_resp_valid, we;
    logic [31:0] mem_data_out, waddr, wdata;

    load_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MEM_WORDS(1024), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .mem_read(mem_read), .req_ready(req_ready),
        .mem_addr2(mem_addr2), .mem_size(mem_size), .mem_sign(mem_sign), .req_tag(req_tag),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid), .mem_data_out(mem_data_out),
        .resp_tag(resp_tag), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
    );

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic [3:0]  tag;
        int          acc;
        int          resp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [16];
    int          cyc = 0;
    int          last_resp = 0;
    int          total = 0;
    int          bad = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] w;
        logic [31:0] r;
        int lane;
        w = mdl_mem[a[5:2]];
        lane = int'(a[1:0]);
        if (sz == 2'd0) begin
            r = (w >> (8 * lane)) & 32'hFF;
            if (!sg && r[7]) r = r | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            r = (w >> (16 * (lane / 2))) & 32'hFFFF;
            if (!sg && r[15]) r = r | 32'hFFFF0000;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3);
    endfunction

    // Edge bookkeeping; a flush at edge f cancels everything not yet visible before f.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && flush) begin
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].resp >= cyc) sb.delete(k);
            end
            last_resp = 0;
        end
    end

    // Monitor: one line per response, plus per-cycle readiness against model occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            int occ;
            exp_t e;
            occ = 0;
            foreach (sb[k]) if (sb[k].acc <= cyc && sb[k].resp - LAT > cyc) occ++;
            check("req_ready", {31'b0, req_ready}, {31'b0, occ < DEPTH});
            while (sb.size() != 0 && sb[0].resp < cyc) begin
                e = sb.pop_front();
                $display("FAIL missing_resp: got none want tag %0d at edge %0d", e.tag, e.resp);
                total++;
                bad++;
            end
            if (mem_resp) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {31'b0, mem_resp}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("resp edge=%0d tag=%0d data=%h valid=%b", cyc, resp_tag, mem_data_out, mem_resp_valid);
                    check("resp_edge", cyc, e.resp);
                    check("resp_tag", {28'b0, resp_tag}, {28'b0, e.tag});
                    check("resp_valid", {31'b0, mem_resp_valid}, {31'b0, e.valid});
                    check("resp_data", mem_data_out, e.data);
                end
            end else begin
                check("valid_idle", {31'b0, mem_resp_valid}, 32'd0);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic [3:0] tg, input logic [31:0] exp_d);
        int   tries;
        bit   fin;
        exp_t e;
        tries = 0;
        fin = 0;
        mem_addr2 = a; mem_size = sz; mem_sign = sg; req_tag = tg; mem_read = 1;
        while (!fin) begin
            if (req_ready) begin
                e.acc   = cyc + 1;
                e.resp  = ((e.acc > last_resp) ? e.acc : last_resp) + LAT;
                last_resp = e.resp;
                e.tag   = tg;
                e.valid = 1'b1;
                e.data  = exp_d;
`ifdef MISALIGN_TRAP_EN
                if (model_mis(a, sz)) begin
                    e.valid = 1'b0;
                    e.data  = 32'd0;
                end
`endif
                sb.push_back(e);
                fin = 1;
            end else begin
                tries++;
                if (tries > 100) begin
                    check("accept_timeout", {31'b0, req_ready}, 32'd1);
                    fin = 1;
                end
            end
            @(negedge clk);
        end
        mem_read = 0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1; waddr = a; wdata = d; wstrb = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clk);
        we = 0;
    endtask

    task automatic do_flush(input logic with_req);
        flush = 1;
        mem_read = with_req;
        mem_addr2 = 32'h4; mem_size = 2'd2; mem_sign = 0; req_tag = 4'hF;
        @(negedge clk);
        flush = 0;
        mem_read = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 0; flush = 0; mem_read = 0; mem_addr2 = 0; mem_size = 0; mem_sign = 0;
        req_tag = 0; we = 0; waddr = 0; wdata = 0; wstrb = 0;
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp", {31'b0, mem_resp}, 32'd0);
        check("rst_valid", {31'b0, mem_resp_valid}, 32'd0);
        check("rst_data", mem_data_out, 32'd0);
        check("rst_tag", {28'b0, resp_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 16; i++) write_word(32'(i * 4), $urandom, 4'hF);

        // Byte/half/word extraction from word 1
        write_word(32'h4, 32'h8899AABB, 4'hF);
        send(32'h5, 2'd0, 1'b0, 4'd3, 32'hFFFFFFAA);
        wait_idle();
        send(32'h6, 2'd1, 1'b1, 4'd4, 32'h00008899);
        send(32'h4, 2'd2, 1'b0, 4'd5, 32'h8899AABB);
        send(32'h7, 2'd0, 1'b1, 4'd6, 32'h00000088);
        wait_idle();

        // Back-to-back burst long enough to fill the queue
        for (int i = 0; i < 12; i++) begin
            a = 32'((i % 16) * 4);
            send(a, 2'd2, 1'b0, 4'(i), model_load(a, 2'd2, 1'b0));
        end
        wait_idle();

        // Flush with requests outstanding, then a fresh request
        for (int i = 0; i < 3; i++) send(32'h8, 2'd2, 1'b0, 4'(i + 1), model_load(32'h8, 2'd2, 1'b0));
        do_flush(1'b1);
        check("ready_after_flush", {31'b0, req_ready}, 32'd1);
        send(32'h4, 2'd0, 1'b0, 4'd9, 32'hFFFFFFBB);
        wait_idle();

        // Write on the response edge is not seen; the next load sees merged data
        send(32'h4, 2'd2, 1'b0, 4'd5, 32'h8899AABB);
        @(negedge clk);
        write_word(32'h4, 32'h11223344, 4'b0011);
        send(32'h4, 2'd2, 1'b0, 4'd6, 32'h88993344);
        wait_idle();

`ifdef MISALIGN_TRAP_EN
        send(32'h6, 2'd2, 1'b0, 4'd2, 32'd0);
        wait_idle();
`endif

        // Randomized mix of loads, flushes, idle cycles and quiescent writes
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            a = $urandom;
            a[11:6] = 6'd0;
            if (r < 65) begin
                logic [1:0] sz;
                logic       sg;
                sz = 2'($urandom_range(0, 3));
                sg = 1'($urandom_range(0, 1));
                send(a, sz, sg, 4'($urandom_range(0, 15)), model_load(a, sz, sg));
            end else if (r < 72) begin
                do_flush(1'($urandom_range(0, 1)));
            end else if (r < 85 && sb.size() == 0) begin
                write_word(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                @(negedge clk);
            end
        end
        wait_idle();

        // Asynchronous reset while a request is in service
        send(32'h4, 2'd2, 1'b0, 4'd7, model_load(32'h4, 2'd2, 1'b0));
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_ready", {31'b0, req_ready}, 32'd1);
        check("arst_resp", {31'b0, mem_resp}, 32'd0);
        check("arst_valid", {31'b0, mem_resp_valid}, 32'd0);
        check("arst_data", mem_data_out, 32'd0);
        check("arst_tag", {28'b0, resp_tag}, 32'd0);
        sb.delete();
        last_resp = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("post_rst_data", mem_data_out, 32'd0);
        send(32'h5, 2'd0, 1'b1, 4'd8, model_load(32'h5, 2'd0, 1'b1));
        wait_idle();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
